// File: rtl/regfile_sb.sv
// Multi-port register file with optional write-to-read bypass and a per-register
// pending scoreboard used by the issue stage for hazard detection.
module regfile_sb #(
    parameter int DW      = 16,
    parameter int AW      = 4,
    parameter bit BYPASS  = 1'b1,
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AW-1:0]         rna,
    input  logic [AW-1:0]         rnb,
    input  logic [AW-1:0]         rnc,
    output logic [DW-1:0]         qa,
    output logic [DW-1:0]         qb,
    output logic [DW-1:0]         qc,
    output logic                  busy_a,
    output logic                  busy_b,
    output logic                  busy_c,
    input  logic [AW-1:0]         wn0,
    input  logic [DW-1:0]         d0,
    input  logic                  we0,
    input  logic [AW-1:0]         wn1,
    input  logic [DW-1:0]         d1,
    input  logic                  we1,
    input  logic                  rsv_en,
    input  logic [AW-1:0]         rsv_n,
    output logic                  rsv_ok,
    output logic [(1<<AW)-1:0]    pend
);

    localparam int NR = 1 << AW;
    localparam int NP = 3;

    logic [DW-1:0]          regs_q [NR];
    logic [DW-1:0]          regs_d [NR];
    logic [NR-1:0]          pend_q;
    logic [NR-1:0]          pend_d;
    logic [NR-1:0]          wr_hit;
    logic [NR-1:0]          rsv_set;
    logic                   rsv_ok_w;

    logic [NP-1:0][AW-1:0]  rn_p;
    logic [NP-1:0][DW-1:0]  q_p;
    logic [NP-1:0]          busy_p;

    // Per-register write-hit and reservation-set decode; R0 is inert when hardwired.
    for (genvar gi = 0; gi < NR; gi++) begin : g_reg
        localparam bit IS_ZERO = ZERO_R0 && (gi == 0);

        assign wr_hit[gi]  = !IS_ZERO &&
                             ((we1 && (wn1 == AW'(gi))) || (we0 && (wn0 == AW'(gi))));
        assign rsv_set[gi] = !IS_ZERO && rsv_en && rsv_ok_w && (rsv_n == AW'(gi));
    end

    assign rsv_ok_w = ~pend_q[rsv_n] | wr_hit[rsv_n];

    // Set wins over clear so a fresh producer is never lost behind the old one's write.
    always_comb begin
        pend_d = pend_q;
        for (int n = 0; n < NR; n++) begin
            if (rsv_set[n]) begin
                pend_d[n] = 1'b1;
            end else if (wr_hit[n]) begin
                pend_d[n] = 1'b0;
            end
        end
    end

    // W1 (loads) is applied after W0 so it wins a same-register collision.
    always_comb begin
        for (int n = 0; n < NR; n++) begin
            regs_d[n] = regs_q[n];
            if (!(ZERO_R0 && (n == 0))) begin
                if (we0 && (wn0 == AW'(n))) begin
                    regs_d[n] = d0;
                end
                if (we1 && (wn1 == AW'(n))) begin
                    regs_d[n] = d1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < NR; n++) begin
                regs_q[n] <= '0;
            end
            pend_q <= '0;
        end else begin
            for (int n = 0; n < NR; n++) begin
                regs_q[n] <= regs_d[n];
            end
            pend_q <= pend_d;
        end
    end

    assign rn_p[0] = rna;
    assign rn_p[1] = rnb;
    assign rn_p[2] = rnc;

    // Identical read ports: hardwired zero, then W1 bypass, then W0 bypass, then array.
    for (genvar gi = 0; gi < NP; gi++) begin : g_rd
        logic [AW-1:0] rn;
        logic          is_zero;
        logic          byp1;
        logic          byp0;

        assign rn      = rn_p[gi];
        assign is_zero = ZERO_R0 && (rn == '0);
        assign byp1    = BYPASS && we1 && (wn1 == rn);
        assign byp0    = BYPASS && we0 && (wn0 == rn);

        always_comb begin
            if (is_zero) begin
                q_p[gi] = '0;
            end else if (byp1) begin
                q_p[gi] = d1;
            end else if (byp0) begin
                q_p[gi] = d0;
            end else begin
                q_p[gi] = regs_q[rn];
            end
        end

        if (BYPASS) begin : g_busy_byp
            assign busy_p[gi] = pend_q[rn] & ~wr_hit[rn];
        end else begin : g_busy_nobyp
            assign busy_p[gi] = pend_q[rn];
        end
    end

    assign qa     = q_p[0];
    assign qb     = q_p[1];
    assign qc     = q_p[2];
    assign busy_a = busy_p[0];
    assign busy_b = busy_p[1];
    assign busy_c = busy_p[2];
    assign rsv_ok = rsv_ok_w;
    assign pend   = pend_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: three instances (default, hardwired R0, no bypass)
// share one stimulus stream; each task checks the instance relevant to it.
module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic [3:0]  rna, rnb, rnc, wn0, wn1, rsv_n;
    logic [15:0] d0, d1;
    logic        we0, we1, rsv_en;

    logic [15:0] qa, qb, qc, pend;
    logic        busy_a, busy_b, busy_c, rsv_ok;
    logic [15:0] z_qa, z_qb, z_qc, z_pend;
    logic        z_busy_a, z_busy_b, z_busy_c, z_rsv_ok;
    logic [15:0] n_qa, n_qb, n_qc, n_pend;
    logic        n_busy_a, n_busy_b, n_busy_c, n_rsv_ok;

    int n_pass;
    int n_total;

    regfile_sb #(.DW(16), .AW(4), .BYPASS(1'b1), .ZERO_R0(1'b0)) u_main (
        .clk(clk), .rst(rst), .rna(rna), .rnb(rnb), .rnc(rnc),
        .qa(qa), .qb(qb), .qc(qc), .busy_a(busy_a), .busy_b(busy_b), .busy_c(busy_c),
        .wn0(wn0), .d0(d0), .we0(we0), .wn1(wn1), .d1(d1), .we1(we1),
        .rsv_en(rsv_en), .rsv_n(rsv_n), .rsv_ok(rsv_ok), .pend(pend));

    regfile_sb #(.DW(16), .AW(4), .BYPASS(1'b1), .ZERO_R0(1'b1)) u_zero (
        .clk(clk), .rst(rst), .rna(rna), .rnb(rnb), .rnc(rnc),
        .qa(z_qa), .qb(z_qb), .qc(z_qc), .busy_a(z_busy_a), .busy_b(z_busy_b), .busy_c(z_busy_c),
        .wn0(wn0), .d0(d0), .we0(we0), .wn1(wn1), .d1(d1), .we1(we1),
        .rsv_en(rsv_en), .rsv_n(rsv_n), .rsv_ok(z_rsv_ok), .pend(z_pend));

    regfile_sb #(.DW(16), .AW(4), .BYPASS(1'b0), .ZERO_R0(1'b0)) u_nobyp (
        .clk(clk), .rst(rst), .rna(rna), .rnb(rnb), .rnc(rnc),
        .qa(n_qa), .qb(n_qb), .qc(n_qc), .busy_a(n_busy_a), .busy_b(n_busy_b), .busy_c(n_busy_c),
        .wn0(wn0), .d0(d0), .we0(we0), .wn1(wn1), .d1(d1), .we1(we1),
        .rsv_en(rsv_en), .rsv_n(rsv_n), .rsv_ok(n_rsv_ok), .pend(n_pend));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0; rsv_en = 1'b0;
        wn0 = 4'd0; wn1 = 4'd0; rsv_n = 4'd0;
        d0 = 16'h0; d1 = 16'h0;
    endtask

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_total++; if (pend !== 16'h0) $display("FAIL reset_pend got=%h exp=%h", pend, 16'h0); else n_pass++;
        n_total++; if (rsv_ok !== 1'b1) $display("FAIL reset_rsv_ok got=%b exp=1", rsv_ok); else n_pass++;
        n_total++; if (qa !== 16'h0) $display("FAIL reset_qa got=%h exp=0000", qa); else n_pass++;
        n_total++; if ({busy_a, busy_b, busy_c} !== 3'b000) $display("FAIL reset_busy got=%b exp=000", {busy_a, busy_b, busy_c}); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_reset_clear();
        we0 = 1'b1; wn0 = 4'd3; d0 = 16'hBEEF;
        rsv_en = 1'b1; rsv_n = 4'd9;
        tick();
        idle();
        rna = 4'd3;
        #1;
        n_total++; if (qa !== 16'hBEEF) $display("FAIL rc_stored got=%h exp=BEEF", qa); else n_pass++;
        n_total++; if (pend !== 16'h0200) $display("FAIL rc_pend_pre got=%h exp=0200", pend); else n_pass++;
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        n_total++; if (qa !== 16'h0) $display("FAIL rc_qa got=%h exp=0000", qa); else n_pass++;
        n_total++; if (pend !== 16'h0) $display("FAIL rc_pend got=%h exp=0000", pend); else n_pass++;
        rsv_n = 4'd9;
        #1;
        n_total++; if (rsv_ok !== 1'b1) $display("FAIL rc_rsv_ok got=%b exp=1", rsv_ok); else n_pass++;
        // Reset held across an edge with a write and reservation pending.
        @(negedge clk);
        rst = 1'b1;
        we0 = 1'b1; wn0 = 4'd3; d0 = 16'h1234; rsv_en = 1'b1; rsv_n = 4'd3;
        tick();
        idle();
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_total++; if (qa !== 16'h0) $display("FAIL rc_mid_qa got=%h exp=0000", qa); else n_pass++;
        n_total++; if (pend !== 16'h0) $display("FAIL rc_mid_pend got=%h exp=0000", pend); else n_pass++;
        $display("test_reset_clear done");
    endtask

    task automatic test_collision();
        we0 = 1'b1; wn0 = 4'd5; d0 = 16'h1111;
        we1 = 1'b1; wn1 = 4'd5; d1 = 16'h2222;
        rna = 4'd5;
        #1;
        n_total++; if (qa !== 16'h2222) $display("FAIL coll_bypass got=%h exp=2222", qa); else n_pass++;
        n_total++; if (n_qa !== 16'h0) $display("FAIL coll_nobyp_old got=%h exp=0000", n_qa); else n_pass++;
        tick();
        idle();
        #1;
        n_total++; if (qa !== 16'h2222) $display("FAIL coll_stored got=%h exp=2222", qa); else n_pass++;
        $display("test_collision done");
    endtask

    task automatic test_reserve_writeback();
        rsv_en = 1'b1; rsv_n = 4'd7;
        #1;
        n_total++; if (rsv_ok !== 1'b1) $display("FAIL rw_rsv_ok got=%b exp=1", rsv_ok); else n_pass++;
        tick();
        idle();
        rnb = 4'd7;
        #1;
        n_total++; if (pend !== 16'h0080) $display("FAIL rw_pend_set got=%h exp=0080", pend); else n_pass++;
        n_total++; if (busy_b !== 1'b1) $display("FAIL rw_busy_set got=%b exp=1", busy_b); else n_pass++;
        we1 = 1'b1; wn1 = 4'd7; d1 = 16'h00A5;
        #1;
        n_total++; if (busy_b !== 1'b0) $display("FAIL rw_busy_wr got=%b exp=0", busy_b); else n_pass++;
        n_total++; if (qb !== 16'h00A5) $display("FAIL rw_qb_wr got=%h exp=00A5", qb); else n_pass++;
        n_total++; if (n_busy_b !== 1'b1) $display("FAIL rw_nobyp_busy got=%b exp=1", n_busy_b); else n_pass++;
        tick();
        idle();
        #1;
        n_total++; if (pend !== 16'h0) $display("FAIL rw_pend_clr got=%h exp=0000", pend); else n_pass++;
        n_total++; if (n_busy_b !== 1'b0) $display("FAIL rw_nobyp_busy_clr got=%b exp=0", n_busy_b); else n_pass++;
        $display("test_reserve_writeback done");
    endtask

    task automatic test_set_wins();
        rsv_en = 1'b1; rsv_n = 4'd2;
        tick();
        idle();
        rsv_en = 1'b1; rsv_n = 4'd2;
        #1;
        n_total++; if (rsv_ok !== 1'b0) $display("FAIL sw_double_ok got=%b exp=0", rsv_ok); else n_pass++;
        tick();
        #1;
        n_total++; if (pend !== 16'h0004) $display("FAIL sw_double_pend got=%h exp=0004", pend); else n_pass++;
        we0 = 1'b1; wn0 = 4'd2; d0 = 16'h0022;
        #1;
        n_total++; if (rsv_ok !== 1'b1) $display("FAIL sw_hit_ok got=%b exp=1", rsv_ok); else n_pass++;
        tick();
        idle();
        rna = 4'd2;
        #1;
        n_total++; if (pend !== 16'h0004) $display("FAIL sw_set_wins got=%h exp=0004", pend); else n_pass++;
        n_total++; if (qa !== 16'h0022) $display("FAIL sw_data got=%h exp=0022", qa); else n_pass++;
        n_total++; if (busy_a !== 1'b1) $display("FAIL sw_busy got=%b exp=1", busy_a); else n_pass++;
        we1 = 1'b1; wn1 = 4'd2; d1 = 16'h0202;
        tick();
        idle();
        #1;
        n_total++; if (pend !== 16'h0) $display("FAIL sw_final_pend got=%h exp=0000", pend); else n_pass++;
        $display("test_set_wins done");
    endtask

    task automatic test_zero_r0();
        we0 = 1'b1; wn0 = 4'd0; d0 = 16'hFFFF;
        rsv_en = 1'b1; rsv_n = 4'd0;
        rna = 4'd0;
        #1;
        n_total++; if (z_qa !== 16'h0) $display("FAIL z_qa_wr got=%h exp=0000", z_qa); else n_pass++;
        n_total++; if (z_rsv_ok !== 1'b1) $display("FAIL z_rsv_ok got=%b exp=1", z_rsv_ok); else n_pass++;
        n_total++; if (qa !== 16'hFFFF) $display("FAIL z_main_bypass got=%h exp=FFFF", qa); else n_pass++;
        tick();
        idle();
        #1;
        n_total++; if (z_pend !== 16'h0) $display("FAIL z_pend got=%h exp=0000", z_pend); else n_pass++;
        n_total++; if (z_qa !== 16'h0) $display("FAIL z_qa_after got=%h exp=0000", z_qa); else n_pass++;
        n_total++; if (pend !== 16'h0001) $display("FAIL z_main_pend got=%h exp=0001", pend); else n_pass++;
        we1 = 1'b1; wn1 = 4'd0; d1 = 16'h0000;
        tick();
        idle();
        #1;
        n_total++; if (pend !== 16'h0) $display("FAIL z_main_clr got=%h exp=0000", pend); else n_pass++;
        $display("test_zero_r0 done");
    endtask

    task automatic test_bypass0();
        we0 = 1'b1; wn0 = 4'd4; d0 = 16'h0AAA;
        tick();
        we0 = 1'b1; wn0 = 4'd4; d0 = 16'h1234;
        rnc = 4'd4;
        #1;
        n_total++; if (n_qc !== 16'h0AAA) $display("FAIL nb_old got=%h exp=0AAA", n_qc); else n_pass++;
        n_total++; if (qc !== 16'h1234) $display("FAIL nb_main_byp got=%h exp=1234", qc); else n_pass++;
        tick();
        idle();
        #1;
        n_total++; if (n_qc !== 16'h1234) $display("FAIL nb_new got=%h exp=1234", n_qc); else n_pass++;
        rsv_en = 1'b1; rsv_n = 4'd6;
        tick();
        idle();
        we1 = 1'b1; wn1 = 4'd6; d1 = 16'h0606;
        rnc = 4'd6;
        #1;
        n_total++; if (n_busy_c !== 1'b1) $display("FAIL nb_busy_wr got=%b exp=1", n_busy_c); else n_pass++;
        n_total++; if (busy_c !== 1'b0) $display("FAIL nb_main_busy got=%b exp=0", busy_c); else n_pass++;
        tick();
        idle();
        #1;
        n_total++; if (n_busy_c !== 1'b0) $display("FAIL nb_busy_clr got=%b exp=0", n_busy_c); else n_pass++;
        n_total++; if (n_pend !== 16'h0) $display("FAIL nb_pend got=%h exp=0000", n_pend); else n_pass++;
        $display("test_bypass0 done");
    endtask

    task automatic test_back_to_back();
        logic [15:0] vals [3];
        logic [15:0] prev;
        vals[0] = 16'h0F01; vals[1] = 16'h0F02; vals[2] = 16'h0F03;
        prev = 16'h0000;
        rna = 4'd15; rnb = 4'd15; rnc = 4'd15;
        for (int i = 0; i < 3; i++) begin
            idle();
            if (i == 1) begin
                we1 = 1'b1; wn1 = 4'd15; d1 = vals[i];
            end else begin
                we0 = 1'b1; wn0 = 4'd15; d0 = vals[i];
            end
            #1;
            n_total++; if (qa !== vals[i] || qc !== vals[i]) $display("FAIL b2b_byp[%0d] qa=%h qc=%h exp=%h", i, qa, qc, vals[i]); else n_pass++;
            n_total++; if (n_qb !== prev) $display("FAIL b2b_nobyp[%0d] got=%h exp=%h", i, n_qb, prev); else n_pass++;
            tick();
            prev = vals[i];
        end
        idle();
        #1;
        n_total++; if (qb !== 16'h0F03 || n_qb !== 16'h0F03) $display("FAIL b2b_final qb=%h n_qb=%h exp=0F03", qb, n_qb); else n_pass++;
        $display("test_back_to_back done");
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        rst = 1'b1;
        rna = 4'd0; rnb = 4'd0; rnc = 4'd0;
        idle();
        test_reset();
        test_reset_clear();
        test_collision();
        test_reserve_writeback();
        test_set_wins();
        test_zero_r0();
        test_bypass0();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-port register file with write bypass and a per-register scoreboard, for the tinyGPU core datapath. It holds 2^AW registers of DW bits. It provides three combinational read ports and two clocked write ports: W0 carries ALU results and W1 carries memory loads. Pending bits block consumers until an outstanding write lands, and the core's issue stage uses them for hazard detection.

## Interface
- DW, 16, register width in bits
- AW, 4, register-number width; depth = 2^AW
- BYPASS, 1, when 1 a same-cycle write is forwarded to the read ports
- ZERO_R0, 0, when 1 register 0 reads as zero, ignores writes and is never pending

Clock and reset: one clock; reset is asynchronous and active-high.

- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  asynchronous active-high reset
- rna, rnb, rnc  in  AW  register numbers for read ports A, B, C
- qa, qb, qc  out  DW  read data for ports A, B, C
- busy_a, busy_b, busy_c  out  1  the register on that read port is pending and not being written this cycle
- wn0  in  AW  register number for write port 0 (ALU)
- d0  in  DW  write data for port 0
- we0  in  1  write enable for port 0
- wn1  in  AW  register number for write port 1 (load)
- d1  in  DW  write data for port 1
- we1  in  1  write enable for port 1
- rsv_en  in  1  request to mark register rsv_n pending
- rsv_n  in  AW  register number to reserve
- rsv_ok  out  1  a reservation of rsv_n is accepted this cycle
- pend  out  2^AW  pending-bit vector; bit n belongs to register n

## Operation
- **Reset:** while rst=1, all registers and all pend bits go to 0 immediately, without waiting for a clock edge. Outputs then follow:
  - qa, qb, qc are 0 unless bypassed;
  - busy_a, busy_b, busy_c are 0;
  - pend is 0;
  - rsv_ok is 1.
- **Write:** on a rising edge, reg[wn0] <= d0 if we0, and reg[wn1] <= d1 if we1.
  - If both ports target the same register, W1 wins and the W0 data is dropped.
  - With ZERO_R0=1, writes to register 0 are discarded.
- **Read:** combinational. The value on port X is selected in this priority order:
  1. ZERO_R0=1 and rnX=0: 0.
  2. BYPASS=1 and we1 and wn1=rnX: d1.
  3. BYPASS=1 and we0 and wn0=rnX: d0.
  4. Otherwise reg[rnX].
- **Write hit:** wr_hit(n) = (we1 & wn1=n) | (we0 & wn0=n). It is forced to 0 for n=0 when ZERO_R0=1.
- **Reservation accept:** rsv_ok = ~pend[rsv_n] | wr_hit(rsv_n). It does not depend on rsv_en.
- **pend[n] update**, next state on the rising edge, in priority order:
  1. Set if rsv_en & rsv_ok & rsv_n=n. Set wins over a simultaneous clear, because the new producer is recorded.
  2. Otherwise cleared if wr_hit(n).
  3. Otherwise held.
  - rsv_en with rsv_ok=0 is ignored, and pend is unchanged.
  - With ZERO_R0=1, pend[0] stays 0 and rsv_ok is 1 for rsv_n=0.
- **Busy flags:**
  - BYPASS=1: busy_X = pend[rnX] & ~wr_hit(rnX).
  - BYPASS=0: busy_X = pend[rnX].
- **Unreserved writes:** a write to a register that is not pending is legal, and the data is stored normally.

## Timing
- Read latency is 0 cycles, combinational from rnX and the array.
- A written value appears in the array after the rising edge. With BYPASS=1 it is also visible on the read ports in the same cycle as the write.
- A reservation becomes visible on pend and busy one cycle after the accepting edge.
- A write clears busy in its own cycle when BYPASS=1. When BYPASS=0, busy clears in the following cycle, when pend drops.
- **Reset mid-operation:** asserting rst in the same cycle as we0, we1 or rsv_en discards them. No write or reservation survives the edge on which rst is high.
- **Reset release:** releasing rst synchronously to clk is the integrator's responsibility. The first accepted write is at the first rising edge with rst=0.
- All read ports may address the same register with no conflict.

## Test plan
- **Reset clear:** write 0xBEEF to R3, then pulse rst between edges. Required: qa=0 with rna=3 immediately after the pulse; pend=0; rsv_ok=1.
- **Dual-write collision:** we0=1, d0=0x1111 and we1=1, d1=0x2222, both to R5. Required: qa reads 0x2222 in the same cycle (BYPASS=1), and R5 reads 0x2222 after the edge.
- **Reserve, then write back:**
  - Reserve R7. Required: pend[7]=1 and busy_b=1 with rnb=7 on the next cycle.
  - Issue we1 to R7 with 0x00A5. Required: busy_b=0 and qb=0x00A5 in that cycle; pend[7]=0 after the edge.
- **Double reservation and set-wins:**
  - Reserve R2 while it is already pending, with no write. Required: rsv_ok=0 and pend unchanged.
  - Repeat with we0 to R2 in the same cycle. Required: rsv_ok=1 and pend[2] stays 1.
- **ZERO_R0=1:** write 0xFFFF to R0 and reserve R0. Required: qa=0 with rna=0; pend[0]=0; rsv_ok=1.
- **BYPASS=0:** we0 to R4 with 0x1234. Required: qc shows the old value in the write cycle and 0x1234 on the next cycle.
